// File: rtl/rr_arb_mux.sv
// N-channel, W-bit arbitrating multiplexer with valid/ready handshakes on every channel.
// Supports round-robin, fixed-priority and direct-select arbitration, with a one-deep registered output.
module rr_arb_mux #(
  parameter int N = 8,
  parameter int W = 32,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_src,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [1:0] {
    MODE_RR         = 2'b00,
    MODE_FIXED      = 2'b01,
    MODE_DIRECT     = 2'b10,
    MODE_DIRECT_ALT = 2'b11
  } mode_e;

  mode_e           mode_sel;
  logic [SELW-1:0] rr_ptr;
  logic            load;
  logic [N-1:0]    hi_mask;
  logic [N-1:0]    cand;
  logic            gnt_any;
  logic [SELW-1:0] gnt_idx;
  logic [N-1:0]    gnt_oh;
  logic [W-1:0]    gnt_data;
  logic [SELW-1:0] nxt_ptr;

  assign mode_sel = mode_e'(mode);
  assign load     = !out_valid || out_ready;

  // Round-robin: prefer requesters at or above rr_ptr, else wrap to the lowest requester.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
    hi_mask  = '0;
    cand     = '0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    gnt_data = '0;
    case (mode_sel)
      MODE_RR: begin
        for (int i = 0; i < N; i++) hi_mask[i] = (i >= int'(rr_ptr));
        cand = ((in_valid & hi_mask) != '0) ? (in_valid & hi_mask) : in_valid;
      end
      MODE_FIXED: cand = in_valid;
      default: begin
        // An out-of-range sel matches no channel, so it never grants.
        for (int i = 0; i < N; i++) cand[i] = in_valid[i] && (sel == SELW'(i));
      end
    endcase
    // Descending scan: the last hit written is the lowest-indexed candidate.
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        gnt_idx   = SELW'(i);
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_data  = in_data[i*W +: W];
      end
    end
    gnt_any = |cand;
  end

  assign in_ready = (!rst && load && gnt_any) ? gnt_oh : '0;
  assign nxt_ptr  = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (gnt_any) begin
        out_data  <= gnt_data;
        out_src   <= gnt_idx;
        out_valid <= 1'b1;
        if (mode_sel == MODE_RR) rr_ptr <= nxt_ptr;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux: one N=4/W=32 instance drives most steps,
// with N=8/W=64 and N=3/W=8 instances for the wide and non-power-of-2 cases.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // N=4, W=32
  logic [1:0]   a_mode;
  logic [1:0]   a_sel;
  logic [127:0] a_in_data;
  logic [3:0]   a_in_valid, a_in_ready;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_src;
  logic         a_out_valid, a_out_ready;

  // N=8, W=64
  logic [1:0]   b_mode;
  logic [2:0]   b_sel;
  logic [511:0] b_in_data;
  logic [7:0]   b_in_valid, b_in_ready;
  logic [63:0]  b_out_data;
  logic [2:0]   b_out_src;
  logic         b_out_valid, b_out_ready;

  // N=3, W=8
  logic [1:0]   c_mode;
  logic [1:0]   c_sel;
  logic [23:0]  c_in_data;
  logic [2:0]   c_in_valid, c_in_ready;
  logic [7:0]   c_out_data;
  logic [1:0]   c_out_src;
  logic         c_out_valid, c_out_ready;

  rr_arb_mux #(.N(4), .W(32)) dut_a (
    .clk(clk), .rst(rst), .mode(a_mode), .sel(a_sel), .in_data(a_in_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_src(a_out_src), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  rr_arb_mux #(.N(8), .W(64)) dut_b (
    .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel), .in_data(b_in_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  rr_arb_mux #(.N(3), .W(8)) dut_c (
    .clk(clk), .rst(rst), .mode(c_mode), .sel(c_sel), .in_data(c_in_data),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_src(c_out_src), .out_valid(c_out_valid), .out_ready(c_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; registered outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected in_ready before the edge, then registered outputs after it (dut_a).
  task automatic a_beat(input string tag, input logic [3:0] exp_rdy, input logic exp_v,
                        input logic [1:0] exp_src, input logic [31:0] exp_data);
    #1;
    check({tag, ".in_ready"}, 64'(a_in_ready), 64'(exp_rdy));
    tick();
    check({tag, ".out_valid"}, 64'(a_out_valid), 64'(exp_v));
    check({tag, ".out_src"}, 64'(a_out_src), 64'(exp_src));
    check({tag, ".out_data"}, 64'(a_out_data), 64'(exp_data));
  endtask

  logic [1:0]  rr_seq [5];
  logic [63:0] b_word;

  initial begin
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    a_mode = 2'b00; a_sel = '0; a_in_valid = 4'b1111; a_out_ready = 1'b1;
    a_in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    b_mode = 2'b00; b_sel = '0; b_in_valid = '0; b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) b_in_data[i*64 +: 64] = {32'hB0 + 32'(i), 32'hC0 + 32'(i)};
    c_mode = 2'b00; c_sel = '0; c_in_valid = '0; c_out_ready = 1'b1;
    c_in_data = {8'h12, 8'h11, 8'h10};

    // 1: reset held two cycles with every channel requesting
    #1;
    check("rst.in_ready", 64'(a_in_ready), 64'h0);
    tick();
    check("rst.in_ready2", 64'(a_in_ready), 64'h0);
    tick();
    check("rst.out_valid", 64'(a_out_valid), 64'h0);
    check("rst.out_data", 64'(a_out_data), 64'h0);
    check("rst.out_src", 64'(a_out_src), 64'h0);
    check("rst.b_out_valid", 64'(b_out_valid), 64'h0);
    rst = 1'b0;

    // 2: round-robin fairness, back-to-back beats
    for (int k = 0; k < 5; k++)
      a_beat($sformatf("rr%0d", k), 4'b0001 << rr_seq[k], 1'b1, rr_seq[k], 32'hA0 + 32'(rr_seq[k]));

    // 3: steer rr_ptr to 3 via a ch2 grant, then wrap/skip with 0101
    a_in_valid = 4'b0100;
    a_beat("wrap.pre", 4'b0100, 1'b1, 2'd2, 32'hA2);
    a_in_valid = 4'b0101;
    a_beat("wrap.0", 4'b0001, 1'b1, 2'd0, 32'hA0);
    a_beat("wrap.2", 4'b0100, 1'b1, 2'd2, 32'hA2);
    a_beat("wrap.0b", 4'b0001, 1'b1, 2'd0, 32'hA0);

    // 4: backpressure with a ch2 beat held (rr_ptr ends at 3)
    a_in_valid = 4'b0100;
    a_beat("bp.load", 4'b0100, 1'b1, 2'd2, 32'hA2);
    a_out_ready = 1'b0;
    a_in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) a_beat($sformatf("bp.hold%0d", k), 4'b0000, 1'b1, 2'd2, 32'hA2);
    a_out_ready = 1'b1;
    a_beat("bp.release", 4'b1000, 1'b1, 2'd3, 32'hA3);

    // 5: fixed priority, then direct select (mode 10 and 11); rr_ptr must stay 0
    a_mode = 2'b01;
    a_in_valid = 4'b1110;
    for (int k = 0; k < 3; k++) a_beat($sformatf("fix%0d", k), 4'b0010, 1'b1, 2'd1, 32'hA1);
    a_mode = 2'b10;
    a_sel = 2'd3;
    a_in_valid = 4'b0111;
    a_beat("dir.none", 4'b0000, 1'b0, 2'd1, 32'hA1);
    a_in_valid = 4'b1111;
    a_beat("dir.3", 4'b1000, 1'b1, 2'd3, 32'hA3);
    a_mode = 2'b11;
    a_sel = 2'd2;
    a_beat("dir11.2", 4'b0100, 1'b1, 2'd2, 32'hA2);
    a_mode = 2'b00;
    a_beat("rr.ptr_kept", 4'b0001, 1'b1, 2'd0, 32'hA0);

    // 6: reset while a beat is held under backpressure (rr_ptr was 1)
    a_out_ready = 1'b0;
    rst = 1'b1;
    a_beat("rst2", 4'b0000, 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    a_out_ready = 1'b1;
    a_beat("rst2.ptr0", 4'b0001, 1'b1, 2'd0, 32'hA0);

    // N=8, W=64: RR over ch2/ch7 then direct select ch7
    b_in_valid = 8'b1000_0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("b.rr%0d.in_ready", k), 64'(b_in_ready), (k == 1) ? 64'h80 : 64'h04);
      tick();
      b_word = (k == 1) ? {32'hB7, 32'hC7} : {32'hB2, 32'hC2};
      check($sformatf("b.rr%0d.out_src", k), 64'(b_out_src), (k == 1) ? 64'd7 : 64'd2);
      check($sformatf("b.rr%0d.out_data", k), b_out_data, b_word);
    end
    b_mode = 2'b10;
    b_sel = 3'd7;
    #1;
    check("b.dir.in_ready", 64'(b_in_ready), 64'h80);
    tick();
    check("b.dir.out_data", b_out_data, {32'hB7, 32'hC7});

    // N=3: sel=3 never grants; RR wraps 2 -> 0
    c_mode = 2'b10;
    c_sel = 2'd3;
    c_in_valid = 3'b111;
    #1;
    check("c.sel3.in_ready", 64'(c_in_ready), 64'h0);
    tick();
    check("c.sel3.out_valid", 64'(c_out_valid), 64'h0);
    c_sel = 2'd2;
    #1;
    check("c.sel2.in_ready", 64'(c_in_ready), 64'h4);
    tick();
    check("c.sel2.out_src", 64'(c_out_src), 64'd2);
    c_mode = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("c.rr%0d.in_ready", k), 64'(c_in_ready), 64'h1 << (k % 3));
      tick();
      check($sformatf("c.rr%0d.out_src", k), 64'(c_out_src), 64'(k % 3));
      check($sformatf("c.rr%0d.out_data", k), 64'(c_out_data), 64'h10 + 64'(k % 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
